// File: rtl/lemming_pkg.sv
// Shared types for the lemming track model: the FSM state encoding and the
// direction encoding that the walker FSM also uses.
package lemming_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRACK = 2'b01,
    S_FAULT = 2'b10
  } state_e;

  // Direction codes, packed as {walking_left, walking_right}.
  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_BOTH  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/lemming_track_model.sv
// Tracks a walker's position on a bounded track, reports wall bumps as
// registered one-cycle pulses and latches a fault on contradictory directions.
module lemming_track_model
  import lemming_pkg::*;
#(
  parameter int TRACK_LEN = 16,
  parameter int START_POS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         step_en,
  input  logic                         walking_left,
  input  logic                         walking_right,
  output logic                         bump_left,
  output logic                         bump_right,
  output logic [$clog2(TRACK_LEN)-1:0] position,
  output logic [CNT_W-1:0]             bump_count,
  output logic                         dir_error,
  output logic [1:0]                   state
);

  localparam int POS_W = $clog2(TRACK_LEN);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(TRACK_LEN - 1);
  localparam logic [POS_W-1:0] POS_RESET = POS_W'(START_POS);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             bump_left_q, bump_left_d;
  logic             bump_right_q, bump_right_d;
  logic             dir_error_q, dir_error_d;
  logic [1:0]       dir;
  logic             track_step;
  logic             bump_inc;

  assign dir = {walking_left, walking_right};

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    bump_left_d  = 1'b0;
    bump_right_d = 1'b0;
    dir_error_d  = dir_error_q;
    track_step   = 1'b0;

    // Contradictory directions win over any step, from every state.
    if (dir == DIR_BOTH) begin
      state_d     = S_FAULT;
      dir_error_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_en && (dir != DIR_NONE)) begin
            state_d    = S_TRACK;
            track_step = 1'b1;
          end
        end
        S_TRACK: track_step = step_en;
        S_FAULT: dir_error_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end

    if (track_step) begin
      case (dir)
        DIR_LEFT: begin
          if (pos_q == '0) bump_left_d = 1'b1;
          else             pos_d       = pos_q - POS_W'(1);
        end
        DIR_RIGHT: begin
          if (pos_q == POS_MAX) bump_right_d = 1'b1;
          else                  pos_d        = pos_q + POS_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pos_q        <= POS_RESET;
      bump_left_q  <= 1'b0;
      bump_right_q <= 1'b0;
      dir_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      bump_left_q  <= bump_left_d;
      bump_right_q <= bump_right_d;
      dir_error_q  <= dir_error_d;
    end
  end

  // Count on the same edge that raises the pulse so both appear together.
  assign bump_inc = bump_left_d | bump_right_d;

  sat_counter #(.WIDTH(CNT_W)) u_bump_counter (
    .clk    (clk),
    .resetn (resetn),
    .inc    (bump_inc),
    .count  (bump_count)
  );

  assign bump_left  = bump_left_q;
  assign bump_right = bump_right_q;
  assign position   = pos_q;
  assign dir_error  = dir_error_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lemming_track_model.sv
// Directed scoreboard bench for lemming_track_model at TRACK_LEN=4,
// START_POS=2, CNT_W=2; a monitor checks every queued expectation.
module tb_lemming_track_model;

  localparam int TRACK_LEN = 4;
  localparam int START_POS = 2;
  localparam int CNT_W     = 2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] pos;
    logic       bl;
    logic       br;
    logic [1:0] cnt;
    logic       derr;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       step_en = 1'b0;
  logic       walking_left = 1'b0;
  logic       walking_right = 1'b0;
  logic       bump_left, bump_right, dir_error;
  logic [1:0] position;
  logic [1:0] bump_count;
  logic [1:0] state;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  lemming_track_model #(
    .TRACK_LEN (TRACK_LEN),
    .START_POS (START_POS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .step_en       (step_en),
    .walking_left  (walking_left),
    .walking_right (walking_right),
    .bump_left     (bump_left),
    .bump_right    (bump_right),
    .position      (position),
    .bump_count    (bump_count),
    .dir_error     (dir_error),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rst_n, input logic en, input logic wl, input logic wr,
                      input logic [1:0] st, input logic [1:0] pos, input logic bl,
                      input logic br, input logic [1:0] cnt, input logic derr,
                      input string name);
    exp_t e;
    @(negedge clk);
    resetn        = rst_n;
    step_en       = en;
    walking_left  = wl;
    walking_right = wr;
    e = '{st: st, pos: pos, bl: bl, br: br, cnt: cnt, derr: derr};
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic check(input exp_t e, input string name);
    exp_t got;
    got = '{st: state, pos: position, bl: bump_left, br: bump_right,
            cnt: bump_count, derr: dir_error};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d pos=%0d bl=%b br=%b cnt=%0d derr=%b, expected state=%0d pos=%0d bl=%b br=%b cnt=%0d derr=%b",
               name, got.st, got.pos, got.bl, got.br, got.cnt, got.derr,
               e.st, e.pos, e.bl, e.br, e.cnt, e.derr);
    end
  endtask

  // Monitor: pops the expectation queued before this edge and compares.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check(exp_q.pop_front(), name_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    //    rst en wl wr  state     pos bl br cnt derr
    // Walk left into the wall; only the third step bumps.
    step(0, 0, 0, 0, ST_IDLE,  2, 0, 0, 0, 0, "reset_state");
    step(1, 1, 1, 0, ST_TRACK, 1, 0, 0, 0, 0, "left_1");
    step(1, 1, 1, 0, ST_TRACK, 0, 0, 0, 0, 0, "left_2");
    step(1, 1, 1, 0, ST_TRACK, 0, 1, 0, 1, 0, "left_blocked");
    step(1, 0, 0, 0, ST_TRACK, 0, 0, 0, 1, 0, "left_pulse_end");

    // Idle steps with no direction keep the FSM idle.
    step(0, 0, 0, 0, ST_IDLE,  2, 0, 0, 0, 0, "reset_2");
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 0, ST_IDLE, 2, 0, 0, 0, 0, "no_dir_step");

    // step_en low ignores a direction.
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 1, ST_IDLE, 2, 0, 0, 0, 0, "right_no_enable");

    // Right wall: five blocked steps, counter saturates at 3.
    step(0, 0, 0, 0, ST_IDLE,  2, 0, 0, 0, 0, "reset_3");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 0, 0, 0, "right_to_max");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 1, 1, 0, "right_blocked_1");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 1, 2, 0, "right_blocked_2");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 1, 3, 0, "right_blocked_3");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 1, 3, 0, "right_blocked_sat_4");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 1, 3, 0, "right_blocked_sat_5");
    step(1, 1, 1, 0, ST_TRACK, 2, 0, 0, 3, 0, "left_from_max");
    step(1, 0, 0, 0, ST_TRACK, 2, 0, 0, 3, 0, "hold_after_sat");

    // Fault from TRACK freezes everything until reset.
    step(0, 0, 0, 0, ST_IDLE,  2, 0, 0, 0, 0, "reset_4");
    step(1, 1, 1, 0, ST_TRACK, 1, 0, 0, 0, 0, "left_to_1");
    step(1, 1, 1, 1, ST_FAULT, 1, 0, 0, 0, 1, "both_dirs_fault");
    step(1, 1, 1, 0, ST_FAULT, 1, 0, 0, 0, 1, "fault_left_frozen");
    step(1, 1, 1, 0, ST_FAULT, 1, 0, 0, 0, 1, "fault_left_frozen_2");
    step(1, 1, 0, 1, ST_FAULT, 1, 0, 0, 0, 1, "fault_right_frozen");
    step(1, 0, 0, 0, ST_FAULT, 1, 0, 0, 0, 1, "fault_idle_frozen");
    step(0, 1, 1, 1, ST_IDLE,  2, 0, 0, 0, 0, "reset_clears_fault");

    // Fault without step_en, straight from IDLE.
    step(1, 0, 1, 1, ST_FAULT, 2, 0, 0, 0, 1, "fault_from_idle");

    // Fault arriving while a bump pulse is showing: pulse ends, count kept.
    step(0, 0, 0, 0, ST_IDLE,  2, 0, 0, 0, 0, "reset_5");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 0, 0, 0, "right_to_max_2");
    step(1, 1, 0, 1, ST_TRACK, 3, 0, 1, 1, 0, "right_blocked_pre_fault");
    step(1, 1, 1, 1, ST_FAULT, 3, 0, 0, 1, 1, "fault_after_bump");

    // Reset on the edge of a blocked step discards the bump.
    step(0, 0, 0, 0, ST_IDLE,  2, 0, 0, 0, 0, "reset_6");
    step(1, 1, 1, 0, ST_TRACK, 1, 0, 0, 0, 0, "left_a");
    step(1, 1, 1, 0, ST_TRACK, 0, 0, 0, 0, 0, "left_b");
    step(0, 1, 1, 0, ST_IDLE,  2, 0, 0, 0, 0, "reset_over_blocked_step");
    step(1, 0, 0, 0, ST_IDLE,  2, 0, 0, 0, 0, "no_late_bump");

    // Bounded drain of the scoreboard.
    @(negedge clk);
    step_en = 1'b0; walking_left = 1'b0; walking_right = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lemming_track_model.md
LEMMING_TRACK_MODEL -- requirements
Module: lemming_track_model

Interface
REQ-001 Parameter TRACK_LEN, default 16, number of track positions (0..TRACK_LEN-1); SHALL be >= 2.
REQ-002 Parameter START_POS, default 8, position loaded on reset; SHALL be < TRACK_LEN.
REQ-003 Parameter CNT_W, default 8, width of bump_count.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 step_en  input  1  one walker step is taken this cycle when high.
REQ-007 walking_left  input  1  walker direction from the walker FSM.
REQ-008 walking_right  input  1  walker direction from the walker FSM.
REQ-009 bump_left  output  1  registered one-cycle pulse; walker hit left wall.
REQ-010 bump_right  output  1  registered one-cycle pulse; walker hit right wall.
REQ-011 position  output  $clog2(TRACK_LEN)  current walker position.
REQ-012 bump_count  output  CNT_W  total bumps since reset, saturating.
REQ-013 dir_error  output  1  sticky; both direction inputs seen high together.
REQ-014 state  output  2  current FSM state encoding, for debug.

Function
REQ-015 FSM states SHALL be S_IDLE, S_TRACK and S_FAULT.
REQ-016 S_IDLE -> S_TRACK on the first cycle with step_en=1 and exactly one of walking_left/walking_right high; that step SHALL be processed as in S_TRACK.
REQ-017 Any state -> S_FAULT in any cycle with walking_left=1 and walking_right=1, regardless of step_en; the fault has priority over a step in the same cycle.
REQ-018 S_FAULT SHALL be exit-only-by-reset: position frozen, bumps 0, bump_count frozen, dir_error=1.
REQ-019 In S_TRACK, step_en=1 with walking_left=1: if position>0, position decrements by 1; if position==0, position holds and bump_left=1 in the next cycle.
REQ-020 In S_TRACK, step_en=1 with walking_right=1: if position<TRACK_LEN-1, position increments by 1; if position==TRACK_LEN-1, position holds and bump_right=1 in the next cycle.
REQ-021 step_en=0, or both direction inputs low, SHALL leave position unchanged and produce no bump and no error.
REQ-022 Bump latency SHALL be exactly one cycle after the blocked step; the pulse width SHALL be one cycle per blocked step, so consecutive blocked steps give consecutive pulses.
REQ-023 bump_left and bump_right SHALL never be high in the same cycle.
REQ-024 bump_count SHALL increment by 1 in the same cycle a bump pulse is asserted, and SHALL saturate at 2^CNT_W-1 without wrap-around.
REQ-025 position SHALL never leave 0..TRACK_LEN-1; no wrap-around at either end.

Reset
REQ-026 When resetn=0 at a rising edge: state=S_IDLE, position=START_POS, bump_left=0, bump_right=0, bump_count=0, dir_error=0.
REQ-027 Reset SHALL override every other input, including in S_FAULT and during a pending bump; a bump due in the next cycle is discarded.

Structure
REQ-028 Package lemming_pkg SHALL hold the state typedef (2-bit enum: S_IDLE=00, S_TRACK=01, S_FAULT=10) and the direction encoding constants shared with the walker FSM.
REQ-029 The saturating counter SHALL be a sub-module sat_counter (parameter WIDTH; ports: clk, resetn, inc, count).
REQ-030 Unused state encoding 11 SHALL decode to S_IDLE on the next edge.

Verification (TRACK_LEN=4, START_POS=2, CNT_W=2)
REQ-031 Reset, then step_en=1 with walking_left=1 for 3 cycles -> position 1, 0, 0; bump_left high only in the cycle after the third step; bump_count=1.
REQ-032 From position 3, hold walking_right with step_en=1 for 5 blocked steps -> bump_right pulses in 5 consecutive cycles; bump_count reads 1, 2, 3, 3, 3 (saturates).
REQ-033 From S_TRACK at position 1, drive walking_left=walking_right=1 with step_en=1 -> S_FAULT, dir_error=1, position stays 1; after inputs are cleared and steps are applied, all values stay frozen.
REQ-034 After reset, step_en=1 with both directions low for 4 cycles -> state stays S_IDLE, position=2, no bumps.
REQ-035 Blocked step at position 0, with resetn=0 on the following edge -> bump_left stays 0, position=2, bump_count=0.
REQ-036 step_en=0 with walking_right=1 for 3 cycles -> position unchanged at 2, no bump_right.
